piradip_ram_arbiter: RTL and testbench

//  Shares one single-port RAM (piradip_ram_if CLIENT side) between NUM_REQ requesters.

---
 rtl/piradip_ram_pkg.sv | 17 +
 rtl/piradip_rr_arbiter.sv | 28 ++
 rtl/piradip_ram_arbiter.sv | 147 ++++++++++++++
 tb/tb_piradip_ram_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piradip_ram_pkg.sv
// Shared types for the single-port RAM arbiter: FSM state and read-return tag.
package piradip_ram_pkg;

    // Tag ID is sized for the largest requester count any arbiter instance may use.
    localparam int unsigned RD_ID_W = 8;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } ram_arb_state_t;

    typedef struct packed {
        logic               v;
        logic [RD_ID_W-1:0] id;
    } ram_rd_tag_t;

endpackage

// File: rtl/piradip_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from last+1, wrapping.
module piradip_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               any,
    output logic [IDX_W-1:0]   grant_idx
);

    always_comb begin
        logic        found;
        int unsigned idx;
        found     = 1'b0;
        idx       = 0;
        grant_idx = '0;
        any       = |req;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(last) + i) % NUM_REQ;
            if (!found && req[IDX_W'(idx)]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/piradip_ram_arbiter.sv
// Shares one single-port RAM between NUM_REQ requesters with round-robin burst locking
// and steers read data back to the issuing requester through a tag pipeline.
module piradip_ram_arbiter
    import piradip_ram_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned WE_WIDTH     = 1,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned HOLD_TIMEOUT = 16
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*WE_WIDTH-1:0]      req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ-1:0]               req_last,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             mem_en,
    output logic [WE_WIDTH-1:0]              mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);

    localparam int unsigned IDX_W    = $clog2(NUM_REQ);
    localparam int unsigned HOLD_W   = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam int unsigned HOLD_MAX = (HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0;

    logic [NUM_REQ-1:0][WE_WIDTH-1:0]   we_arr;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_arr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_arr;

    ram_arb_state_t     state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               arb_any;
    logic [IDX_W-1:0]   arb_idx;
    logic               accept;
    logic               rd_beat;
    ram_rd_tag_t        tag_q [READ_LATENCY];
    ram_rd_tag_t        tag_tail;

    assign we_arr    = req_we;
    assign addr_arr  = req_addr;
    assign wdata_arr = req_wdata;

    piradip_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .last      (last_owner_q),
        .any       (arb_any),
        .grant_idx (arb_idx)
    );

    // Next-state and RAM-side outputs; everything is forced quiet while reset is high.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        req_ready    = '0;
        mem_en       = 1'b0;
        mem_we       = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        accept       = 1'b0;
        case (state_q)
            ARB: begin
                if (arb_any) begin
                    state_d    = OWN;
                    owner_d    = arb_idx;
                    hold_cnt_d = '0;
                end
            end
            OWN: begin
                if (!areset) begin
                    req_ready[owner_q] = 1'b1;
                    mem_addr           = addr_arr[owner_q];
                    mem_wdata          = wdata_arr[owner_q];
                end
                accept = req_valid[owner_q] && !areset;
                if (accept) begin
                    mem_en     = 1'b1;
                    mem_we     = we_arr[owner_q];
                    hold_cnt_d = '0;
                    if (req_last[owner_q]) begin
                        state_d      = ARB;
                        last_owner_d = owner_q;
                    end
                end else if (HOLD_TIMEOUT > 0) begin
                    // Idle owner: release once the idle run reaches the timeout.
                    if (hold_cnt_q == HOLD_W'(HOLD_MAX)) begin
                        state_d      = ARB;
                        last_owner_d = owner_q;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign rd_beat  = accept && (mem_we == '0);
    assign tag_tail = tag_q[READ_LATENCY-1];
    assign rsp_data = mem_rdata;

    always_comb begin
        rsp_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!areset && tag_tail.v && (tag_tail.id == RD_ID_W'(i))) begin
                rsp_valid[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ARB;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            hold_cnt_q   <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            // Tag pipeline drains regardless of ownership changes.
            tag_q[0] <= '{v: rd_beat, id: RD_ID_W'(owner_q)};
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_piradip_ram_arbiter.sv
// Directed bench: instance A (2 req, latency 3, timeout 4), instance B (3 req, latency 2, no timeout).
module tb_piradip_ram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic areset;
    int   vectors     = 0;
    int   miscompares = 0;

    // Instance A signals
    logic [1:0]  a_req_valid, a_req_ready, a_req_we, a_req_last, a_rsp_valid;
    logic [19:0] a_req_addr;
    logic [63:0] a_req_wdata;
    logic [31:0] a_rsp_data, a_mem_wdata, a_mem_rdata;
    logic        a_mem_en;
    logic [0:0]  a_mem_we;
    logic [9:0]  a_mem_addr;

    // Instance B signals
    logic [2:0]  b_req_valid, b_req_ready, b_req_we, b_req_last, b_rsp_valid;
    logic [29:0] b_req_addr;
    logic [95:0] b_req_wdata;
    logic [31:0] b_rsp_data, b_mem_wdata, b_mem_rdata;
    logic        b_mem_en;
    logic [0:0]  b_mem_we;
    logic [9:0]  b_mem_addr;

    piradip_ram_arbiter #(
        .NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(10), .WE_WIDTH(1),
        .READ_LATENCY(3), .HOLD_TIMEOUT(4)
    ) dut_a (
        .aclk(clk), .areset(areset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_last(a_req_last),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    piradip_ram_arbiter #(
        .NUM_REQ(3), .DATA_WIDTH(32), .ADDR_WIDTH(10), .WE_WIDTH(1),
        .READ_LATENCY(2), .HOLD_TIMEOUT(0)
    ) dut_b (
        .aclk(clk), .areset(areset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_last(b_req_last),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // RAM stand-ins: a word reads back as a tag in the top byte plus its address.
    logic [31:0] a_pipe [3];
    logic [31:0] b_pipe [2];
    always @(posedge clk) begin
        a_pipe[0] <= 32'hA000_0000 | 32'(a_mem_addr);
        a_pipe[1] <= a_pipe[0];
        a_pipe[2] <= a_pipe[1];
        b_pipe[0] <= 32'hB000_0000 | 32'(b_mem_addr);
        b_pipe[1] <= b_pipe[0];
    end
    assign a_mem_rdata = a_pipe[2];
    assign b_mem_rdata = b_pipe[1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_req_valid = '0; a_req_we = '0; a_req_last = '0; a_req_addr = '0; a_req_wdata = '0;
    endtask

    task automatic b_idle();
        b_req_valid = '0; b_req_we = '0; b_req_last = '0; b_req_addr = '0; b_req_wdata = '0;
    endtask

    task automatic a_drive(input int r, input logic v, input logic we, input logic [9:0] addr,
                           input logic [31:0] wd, input logic last);
        a_req_valid[r] = v; a_req_we[r] = we; a_req_last[r] = last;
        a_req_addr[r*10 +: 10] = addr; a_req_wdata[r*32 +: 32] = wd;
    endtask

    task automatic b_drive(input int r, input logic v, input logic we, input logic [9:0] addr,
                           input logic [31:0] wd, input logic last);
        b_req_valid[r] = v; b_req_we[r] = we; b_req_last[r] = last;
        b_req_addr[r*10 +: 10] = addr; b_req_wdata[r*32 +: 32] = wd;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        a_idle(); b_idle();
        a_drive(0, 1'b1, 1'b1, 10'h3FF, 32'hFFFF_FFFF, 1'b0);
        b_drive(1, 1'b1, 1'b0, 10'h155, 32'h1234_5678, 1'b0);
        tick(); tick(); #1;
        vectors++;
        if ({a_req_ready, a_rsp_valid, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_a_outputs: ready=%b rsp=%b en=%b we=%b addr=%h wdata=%h, want all 0",
                     a_req_ready, a_rsp_valid, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
        end
        vectors++;
        if ({b_req_ready, b_rsp_valid, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_b_outputs: ready=%b rsp=%b en=%b addr=%h, want all 0",
                     b_req_ready, b_rsp_valid, b_mem_en, b_mem_addr);
        end
        tick();
        areset = 1'b0;
        a_idle(); b_idle();
        #1;
        vectors++;
        if ({a_req_ready, a_mem_en, b_req_ready, b_mem_en} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_release: a_ready=%b a_en=%b b_ready=%b b_en=%b, want 0",
                     a_req_ready, a_mem_en, b_req_ready, b_mem_en);
        end
    endtask

    // Both request out of reset: req0 bursts 4 writes, bubble, then req1 bursts 4 writes.
    task automatic test_rr_writes();
        tick();
        a_drive(0, 1'b1, 1'b1, 10'h010, 32'hD000_0000, 1'b0);
        a_drive(1, 1'b1, 1'b1, 10'h020, 32'hE000_0000, 1'b0);
        #1;
        vectors++;
        if ({a_req_ready, a_mem_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL t1_arb: ready=%b en=%b, want 00/0", a_req_ready, a_mem_en);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            a_drive(0, 1'b1, 1'b1, 10'(16 + k), 32'(32'hD000_0000 + k), (k == 3));
            #1;
            vectors++;
            if ({a_req_ready, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !==
                {2'b01, 1'b1, 1'b1, 10'(16 + k), 32'(32'hD000_0000 + k)}) begin
                miscompares++;
                $display("FAIL t1_req0_beat%0d: ready=%b en=%b we=%b addr=%h wdata=%h, want 01/1/1/%h/%h",
                         k, a_req_ready, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata,
                         10'(16 + k), 32'(32'hD000_0000 + k));
            end
        end
        tick();
        a_drive(0, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0);
        #1;
        vectors++;
        if ({a_req_ready, a_mem_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL t1_bubble: ready=%b en=%b, want 00/0", a_req_ready, a_mem_en);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            a_drive(1, 1'b1, 1'b1, 10'(32 + k), 32'(32'hE000_0000 + k), (k == 3));
            #1;
            vectors++;
            if ({a_req_ready, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !==
                {2'b10, 1'b1, 1'b1, 10'(32 + k), 32'(32'hE000_0000 + k)}) begin
                miscompares++;
                $display("FAIL t1_req1_beat%0d: ready=%b en=%b we=%b addr=%h wdata=%h, want 10/1/1/%h/%h",
                         k, a_req_ready, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata,
                         10'(32 + k), 32'(32'hE000_0000 + k));
            end
        end
        tick();
        a_idle();
        #1;
        vectors++;
        if ({a_req_ready, a_mem_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL t1_end: ready=%b en=%b, want 00/0", a_req_ready, a_mem_en);
        end
    endtask

    // req0 single-beat read of 0x5 on the latency-3 instance.
    task automatic test_read_latency();
        tick();
        a_drive(0, 1'b1, 1'b0, 10'h005, 32'h0, 1'b1);
        #1;
        vectors++;
        if (a_req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL t2_arb: ready=%b, want 00", a_req_ready);
        end
        tick();
        vectors++;
        if ({a_req_ready, a_mem_en, a_mem_we, a_mem_addr} !== {2'b01, 1'b1, 1'b0, 10'h005}) begin
            miscompares++;
            $display("FAIL t2_accept: ready=%b en=%b we=%b addr=%h, want 01/1/0/005",
                     a_req_ready, a_mem_en, a_mem_we, a_mem_addr);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            a_idle();
            #1;
            vectors++;
            if (k == 3) begin
                if ({a_rsp_valid, a_rsp_data} !== {2'b01, 32'hA000_0005}) begin
                    miscompares++;
                    $display("FAIL t2_rsp_c%0d: rsp_valid=%b data=%h, want 01/a0000005",
                             k, a_rsp_valid, a_rsp_data);
                end
            end else if (a_rsp_valid !== 2'b00) begin
                miscompares++;
                $display("FAIL t2_quiet_c%0d: rsp_valid=%b, want 00", k, a_rsp_valid);
            end
        end
    endtask

    // req1 one-beat read then req0 takes over; req1's data still returns 2 cycles later.
    task automatic test_read_handoff();
        tick();
        b_drive(1, 1'b1, 1'b0, 10'h007, 32'h0, 1'b1);
        #1;
        vectors++;
        if (b_req_ready !== 3'b000) begin
            miscompares++;
            $display("FAIL t3_arb: ready=%b, want 000", b_req_ready);
        end
        tick();
        b_drive(0, 1'b1, 1'b0, 10'h009, 32'h0, 1'b1);
        #1;
        vectors++;
        if ({b_req_ready, b_mem_en, b_mem_addr} !== {3'b010, 1'b1, 10'h007}) begin
            miscompares++;
            $display("FAIL t3_req1_accept: ready=%b en=%b addr=%h, want 010/1/007",
                     b_req_ready, b_mem_en, b_mem_addr);
        end
        tick();
        b_drive(1, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0);
        #1;
        vectors++;
        if ({b_req_ready, b_rsp_valid} !== 6'b000000) begin
            miscompares++;
            $display("FAIL t3_bubble: ready=%b rsp_valid=%b, want 000/000", b_req_ready, b_rsp_valid);
        end
        tick();
        vectors++;
        if ({b_rsp_valid, b_rsp_data, b_req_ready, b_mem_en, b_mem_addr} !==
            {3'b010, 32'hB000_0007, 3'b001, 1'b1, 10'h009}) begin
            miscompares++;
            $display("FAIL t3_rsp1_own0: rsp=%b data=%h ready=%b en=%b addr=%h, want 010/b0000007/001/1/009",
                     b_rsp_valid, b_rsp_data, b_req_ready, b_mem_en, b_mem_addr);
        end
        tick();
        b_idle();
        #1;
        vectors++;
        if (b_rsp_valid !== 3'b000) begin
            miscompares++;
            $display("FAIL t3_quiet: rsp_valid=%b, want 000", b_rsp_valid);
        end
        tick();
        vectors++;
        if ({b_rsp_valid, b_rsp_data} !== {3'b001, 32'hB000_0009}) begin
            miscompares++;
            $display("FAIL t3_rsp0: rsp_valid=%b data=%h, want 001/b0000009", b_rsp_valid, b_rsp_data);
        end
        tick();
        vectors++;
        if (b_rsp_valid !== 3'b000) begin
            miscompares++;
            $display("FAIL t3_tail: rsp_valid=%b, want 000", b_rsp_valid);
        end
    endtask

    // req1 stalls mid-burst for 4 cycles; lock holds, then waiting req0 is granted.
    task automatic test_timeout();
        tick();
        a_drive(1, 1'b1, 1'b1, 10'h040, 32'hC0DE_0040, 1'b0);
        #1;
        vectors++;
        if (a_req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL t4_arb: ready=%b, want 00", a_req_ready);
        end
        tick();
        a_drive(0, 1'b1, 1'b1, 10'h030, 32'hC0DE_0030, 1'b1);
        #1;
        vectors++;
        if ({a_req_ready, a_mem_en, a_mem_addr} !== {2'b10, 1'b1, 10'h040}) begin
            miscompares++;
            $display("FAIL t4_first_beat: ready=%b en=%b addr=%h, want 10/1/040",
                     a_req_ready, a_mem_en, a_mem_addr);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            a_drive(1, 1'b0, 1'b1, 10'h041, 32'h0, 1'b0);
            #1;
            vectors++;
            if ({a_req_ready, a_mem_en} !== {2'b10, 1'b0}) begin
                miscompares++;
                $display("FAIL t4_hold%0d: ready=%b en=%b, want 10/0", k, a_req_ready, a_mem_en);
            end
        end
        tick();
        vectors++;
        if ({a_req_ready, a_mem_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL t4_release: ready=%b en=%b, want 00/0", a_req_ready, a_mem_en);
        end
        tick();
        vectors++;
        if ({a_req_ready, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !==
            {2'b01, 1'b1, 1'b1, 10'h030, 32'hC0DE_0030}) begin
            miscompares++;
            $display("FAIL t4_req0_grant: ready=%b en=%b we=%b addr=%h wdata=%h, want 01/1/1/030/c0de0030",
                     a_req_ready, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
        end
        tick();
        a_idle();
        #1;
        vectors++;
        if (a_req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL t4_end: ready=%b, want 00", a_req_ready);
        end
    endtask

    // Reset lands mid-burst with two reads in flight.
    task automatic test_reset_inflight();
        tick();
        a_drive(1, 1'b1, 1'b0, 10'h001, 32'h0, 1'b0);
        #1;
        tick();
        vectors++;
        if ({a_req_ready, a_mem_en, a_mem_we, a_mem_addr} !== {2'b10, 1'b1, 1'b0, 10'h001}) begin
            miscompares++;
            $display("FAIL t5_read1: ready=%b en=%b we=%b addr=%h, want 10/1/0/001",
                     a_req_ready, a_mem_en, a_mem_we, a_mem_addr);
        end
        tick();
        a_drive(1, 1'b1, 1'b0, 10'h002, 32'h0, 1'b0);
        #1;
        vectors++;
        if ({a_req_ready, a_mem_en, a_mem_we, a_mem_addr} !== {2'b10, 1'b1, 1'b0, 10'h002}) begin
            miscompares++;
            $display("FAIL t5_read2: ready=%b en=%b we=%b addr=%h, want 10/1/0/002",
                     a_req_ready, a_mem_en, a_mem_we, a_mem_addr);
        end
        tick();
        areset = 1'b1;
        a_drive(1, 1'b1, 1'b0, 10'h003, 32'h0, 1'b0);
        #1;
        vectors++;
        if ({a_req_ready, a_rsp_valid, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL t5_in_reset: ready=%b rsp=%b en=%b addr=%h, want all 0",
                     a_req_ready, a_rsp_valid, a_mem_en, a_mem_addr);
        end
        tick();
        a_drive(0, 1'b1, 1'b1, 10'h050, 32'h5050_5050, 1'b1);
        #1;
        vectors++;
        if ({a_req_ready, a_rsp_valid, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL t5_reset_hold: ready=%b rsp=%b en=%b addr=%h, want all 0",
                     a_req_ready, a_rsp_valid, a_mem_en, a_mem_addr);
        end
        tick();
        areset = 1'b0;
        #1;
        vectors++;
        if ({a_req_ready, a_rsp_valid, a_mem_en} !== 5'b00000) begin
            miscompares++;
            $display("FAIL t5_after_reset: ready=%b rsp=%b en=%b, want 00/00/0",
                     a_req_ready, a_rsp_valid, a_mem_en);
        end
        tick();
        vectors++;
        if ({a_req_ready, a_rsp_valid, a_mem_en, a_mem_we, a_mem_addr} !==
            {2'b01, 2'b00, 1'b1, 1'b1, 10'h050}) begin
            miscompares++;
            $display("FAIL t5_new_owner: ready=%b rsp=%b en=%b we=%b addr=%h, want 01/00/1/1/050",
                     a_req_ready, a_rsp_valid, a_mem_en, a_mem_we, a_mem_addr);
        end
        tick();
        a_idle();
        #1;
        vectors++;
        if ({a_req_ready, a_rsp_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL t5_end: ready=%b rsp=%b, want 00/00", a_req_ready, a_rsp_valid);
        end
    endtask

    // Three requesters with continuous one-beat bursts after reset: order 0,1,2,0,1,2.
    task automatic test_rr_wrap();
        tick();
        areset = 1'b1;
        a_idle(); b_idle();
        tick();
        areset = 1'b0;
        for (int r = 0; r < 3; r++) begin
            b_drive(r, 1'b1, 1'b1, 10'(96 + r), 32'(32'h6000_0000 + r), 1'b1);
        end
        #1;
        for (int g = 0; g < 6; g++) begin
            vectors++;
            if ({b_req_ready, b_mem_en} !== 4'b0000) begin
                miscompares++;
                $display("FAIL t6_bubble%0d: ready=%b en=%b, want 000/0", g, b_req_ready, b_mem_en);
            end
            tick();
            vectors++;
            if ({b_req_ready, b_mem_en, b_mem_we, b_mem_addr} !==
                {3'(1 << (g % 3)), 1'b1, 1'b1, 10'(96 + (g % 3))}) begin
                miscompares++;
                $display("FAIL t6_grant%0d: ready=%b en=%b we=%b addr=%h, want %b/1/1/%h",
                         g, b_req_ready, b_mem_en, b_mem_we, b_mem_addr,
                         3'(1 << (g % 3)), 10'(96 + (g % 3)));
            end
            tick();
        end
        b_idle();
    endtask

    initial begin
        test_reset();
        test_rr_writes();
        test_read_latency();
        test_read_handoff();
        test_timeout();
        test_reset_inflight();
        test_rr_wrap();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
